spi_slave_phy: RTL and testbench
================================

# spi_slave_phy

SPI slave physical front end that oversamples the external SPI pins in the `clock` domain. It deserialises MOSI into a 32-bit word and maintains the frame bit counter. It serialises read-back data onto MISO. It sits directly upstream of the SPI-to-Avalon bridge state machine, feeding it `bit_cnt`, `rx_data` and `csn_sync`, and taking `tx_data` (the bridge's read data) back.

## Interface
Parameters:
- `WORD_BITS`, 32: bits per address/data word; frame = address word + N data words.

Ports:
- `clock`  in  1  system clock; all logic synchronous to it.
- `nreset`  in  1  reset, asynchronous, active-low.
- `spi_sclk`  in  1  SPI serial clock, asynchronous to `clock`.
- `spi_csn`  in  1  SPI chip select, active-low, asynchronous.
- `spi_mosi`  in  1  serial data in, MSB first.
- `spi_miso`  out  1  serial data out, MSB first.
- `spi_miso_oe`  out  1  MISO output enable; 1 while `csn_sync` low.
- `tx_data`  in  32  word to transmit; from bridge read data.
- `csn_sync`  out  1  synchronised chip select for the bridge.
- `bit_cnt`  out  7  frame bit position.
- `rx_data`  out  32  last 32 received bits, MSB = earliest.
- `word_done`  out  1  1-cycle pulse when `bit_cnt` becomes 32 or 64.

## Operation
- Sync: 2-flop synchroniser on `spi_sclk`, `spi_csn` and `spi_mosi`, plus a 3rd flop on `spi_sclk` for edge detection. `rise`/`fall` are single-cycle strobes.
- `csn_sync` high (idle):
  - `bit_cnt`=0, `rx_data`=0, tx shift register=0.
  - `spi_miso`=0, `spi_miso_oe`=0, `word_done`=0.
  - All edges are ignored.
- On `rise` with `csn_sync` low:
  - `rx_data` <= {`rx_data`[30:0], mosi_sync}.
  - `bit_cnt` increments.
  - Wrap rule: 64 -> 33, never 65. Each further data word therefore re-reaches 64.
- On `fall` with `csn_sync` low:
  - If `bit_cnt`==32 or 64, load the tx shift register from `tx_data` and drive bit 31 on MISO.
  - Else if `bit_cnt`>32, shift left and present the next bit.
  - Else hold MISO=0 (address phase).
- MISO is the MSB of the tx shift register. It is 0 during bits 0-32.
- `word_done` asserts in the same cycle `bit_cnt` transitions to 32 or 64.
- Reset: all outputs 0 except `csn_sync`=1. The `spi_sclk` synchroniser resets to the idle SCLK level.
- `csn` rising mid-word: all state clears within 3 clocks. The partial word is discarded and no `word_done` is issued.
- `rise` and `csn` deassert in the same cycle: the deassert wins.

## Timing
- Pin to strobe: 2-3 `clock` cycles of latency; `bit_cnt`/`rx_data` update 1 cycle after `rise`.
- `clock` frequency is at least 8x `spi_sclk`. Both SCLK high and SCLK low last at least 4 clocks.
- `tx_data` is sampled in the cycle `fall` is detected after bit 32/64.
  - The host inserts an SCLK-low turnaround after bit 32, covering Avalon read latency plus 4 clocks.
  - Between successive read words, the bridge's next read must also complete before the falling edge after bit 64.
- MISO changes 3-4 clocks after the SCLK falling pin edge. It is stable before the next rising pin edge.

## Configuration
- `SPI_MODE3_EN` undefined: SPI mode 0 (CPOL=0, CPHA=0).
  - SCLK sync flops reset to 0.
  - A `fall` at `bit_cnt`==0 cannot occur.
- `SPI_MODE3_EN` defined: SPI mode 3 (CPOL=1, CPHA=1).
  - SCLK sync flops reset to 1.
  - The leading `fall` at `bit_cnt`==0 after csn assert is ignored.
  - Sampling stays on rising edges and shifting on falling edges; all counts are unchanged.

## Structure
- Package `spi_pkg`: `SPI_ADDR_BITS`=32, `SPI_FRAME_BITS`=64, `SPI_WRAP_BITS`=33, `SPI_CNT_W`=7. These are shared with the bridge.
- Sub-module `spi_sync_edge`: N-flop synchroniser with a reset-value parameter and `rise`/`fall` outputs. It is instantiated for SCLK and csn; MOSI uses the plain synchroniser path.

## Test plan
- Write frame: address 0x00000010 (bit31=0), then data 0xA5A5_1234 -> `bit_cnt` 32 with `rx_data`=0x00000010 and `word_done` pulse; then `bit_cnt` 64 with `rx_data`=0xA5A51234; MISO=0 throughout.
- Read frame: address 0x80000020, `tx_data`=0xDEADBEEF stable through the turnaround -> MISO bits 33-64 read 0xDEADBEEF MSB-first; `spi_miso_oe`=1 only while csn is low.
- Burst: 3 data words after the address -> `bit_cnt` sequence ...64,33,...,64,33,...,64; `word_done` pulses at 32 and three times at 64.
- csn raised after 17 bits -> within 3 clocks `bit_cnt`=0, `rx_data`=0, no `word_done`.
- Async `nreset` asserted mid-frame -> immediate all-zero outputs, `csn_sync`=1; normal frame afterwards.
- `SPI_MODE3_EN` defined, idle SCLK high: repeat the read frame -> identical `rx_data`/MISO results, leading fall ignored.

Source files
------------

// File: rtl/spi_slave_phy_pkg.sv
// Frame constants and counter helpers shared by the SPI slave PHY and the SPI-to-Avalon bridge.
package spi_pkg;

    localparam int SPI_ADDR_BITS  = 32;
    localparam int SPI_FRAME_BITS = 64;
    localparam int SPI_WRAP_BITS  = 33;
    localparam int SPI_CNT_W      = 7;

    typedef logic [SPI_CNT_W-1:0] spi_cnt_t;

    function automatic logic spi_word_boundary(input spi_cnt_t cnt);
        return (cnt == spi_cnt_t'(SPI_ADDR_BITS)) || (cnt == spi_cnt_t'(SPI_FRAME_BITS));
    endfunction

    // After the first data word the counter wraps so every further word ends at 64 again.
    function automatic spi_cnt_t spi_cnt_next(input spi_cnt_t cnt);
        spi_cnt_t nxt;
        if (cnt == spi_cnt_t'(SPI_FRAME_BITS)) begin
            nxt = spi_cnt_t'(SPI_WRAP_BITS);
        end else begin
            nxt = cnt + spi_cnt_t'(1'b1);
        end
        return nxt;
    endfunction

endpackage

// File: rtl/spi_slave_phy_if.sv
// Bridge-facing bundle of the SPI slave PHY: master = PHY side, slave = bridge side.
interface spi_slave_phy_if
    import spi_pkg::*;
#(
    parameter int WORD_BITS = 32
) ();

    logic                 csn_sync;
    logic [SPI_CNT_W-1:0] bit_cnt;
    logic [WORD_BITS-1:0] rx_data;
    logic                 word_done;
    logic [WORD_BITS-1:0] tx_data;

    modport master (
        output csn_sync,
        output bit_cnt,
        output rx_data,
        output word_done,
        input  tx_data
    );

    modport slave (
        input  csn_sync,
        input  bit_cnt,
        input  rx_data,
        input  word_done,
        output tx_data
    );

endinterface

// File: rtl/spi_slave_phy_sync_edge.sv
// N-flop synchroniser with one extra history flop producing single-cycle rise/fall strobes.
module spi_sync_edge #(
    parameter int   STAGES  = 2,
    parameter logic RST_VAL = 1'b0
) (
    input  logic clock,
    input  logic nreset,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [STAGES-1:0] r_sync;
    logic              r_prev;

    // synchroniser chain plus edge-history flop
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_sync <= {STAGES{RST_VAL}};
            r_prev <= RST_VAL;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_async};
            r_prev <= r_sync[STAGES-1];
        end
    end

    assign o_sync = r_sync[STAGES-1];
    assign o_rise = r_sync[STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[STAGES-1] & r_prev;

endmodule

// File: rtl/spi_slave_phy.sv
// SPI slave PHY: oversampled SCLK/CSN/MOSI, MOSI deserialiser, frame bit counter and MISO serialiser.
// Build option: define SPI_MODE3_EN for SPI mode 3 (idle SCLK high); SPI mode 0 otherwise.
module spi_slave_phy
    import spi_pkg::*;
#(
    parameter int WORD_BITS = 32
) (
    input  logic            clock,
    input  logic            nreset,
    input  logic            spi_sclk,
    input  logic            spi_csn,
    input  logic            spi_mosi,
    output logic            spi_miso,
    output logic            spi_miso_oe,
    spi_slave_phy_if.master bus
);

    logic                 w_sclk_sync;
    logic                 w_sclk_rise;
    logic                 w_sclk_fall;
    logic                 w_csn_sync;
    logic                 w_csn_rise;
    logic                 w_csn_fall;
    logic                 w_fall_act;
    logic                 w_clear;
    logic                 w_unused;
    logic                 r_mosi_meta;
    logic                 r_mosi_sync;
    spi_cnt_t             r_bit_cnt;
    spi_cnt_t             w_bit_cnt_nxt;
    logic [WORD_BITS-1:0] r_rx_data;
    logic [WORD_BITS-1:0] w_rx_nxt;
    logic [WORD_BITS-1:0] r_tx_shift;
    logic [WORD_BITS-1:0] w_tx_nxt;
    logic                 r_word_done;
    logic                 w_word_done_nxt;

`ifdef SPI_MODE3_EN
    localparam logic SCLK_IDLE = 1'b1;
    // the leading falling edge right after chip select is not a shift edge
    assign w_fall_act = w_sclk_fall & (r_bit_cnt != {SPI_CNT_W{1'b0}});
`else
    localparam logic SCLK_IDLE = 1'b0;
    assign w_fall_act = w_sclk_fall;
`endif

    spi_sync_edge #(.STAGES(2), .RST_VAL(SCLK_IDLE)) u_sclk_sync (
        .clock   (clock),
        .nreset  (nreset),
        .i_async (spi_sclk),
        .o_sync  (w_sclk_sync),
        .o_rise  (w_sclk_rise),
        .o_fall  (w_sclk_fall)
    );

    spi_sync_edge #(.STAGES(2), .RST_VAL(1'b1)) u_csn_sync (
        .clock   (clock),
        .nreset  (nreset),
        .i_async (spi_csn),
        .o_sync  (w_csn_sync),
        .o_rise  (w_csn_rise),
        .o_fall  (w_csn_fall)
    );

    assign w_unused = w_sclk_sync ^ w_csn_fall;
    assign w_clear  = w_csn_sync | w_csn_rise;

    // plain two-flop MOSI synchroniser, same latency as the SCLK strobes
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
        end else begin
            r_mosi_meta <= spi_mosi;
            r_mosi_sync <= r_mosi_meta;
        end
    end

    // next state: chip-select clear dominates any strobe in the same cycle
    always_comb begin
        w_bit_cnt_nxt   = r_bit_cnt;
        w_rx_nxt        = r_rx_data;
        w_tx_nxt        = r_tx_shift;
        w_word_done_nxt = 1'b0;
        if (w_clear) begin
            w_bit_cnt_nxt = {SPI_CNT_W{1'b0}};
            w_rx_nxt      = {WORD_BITS{1'b0}};
            w_tx_nxt      = {WORD_BITS{1'b0}};
        end else if (w_sclk_rise) begin
            w_bit_cnt_nxt   = spi_cnt_next(r_bit_cnt);
            w_rx_nxt        = {r_rx_data[WORD_BITS-2:0], r_mosi_sync};
            w_word_done_nxt = spi_word_boundary(w_bit_cnt_nxt);
        end else if (w_fall_act) begin
            if (spi_word_boundary(r_bit_cnt)) begin
                w_tx_nxt = bus.tx_data;
            end else if (r_bit_cnt > spi_cnt_t'(SPI_ADDR_BITS)) begin
                w_tx_nxt = {r_tx_shift[WORD_BITS-2:0], 1'b0};
            end else begin
                w_tx_nxt = {WORD_BITS{1'b0}};
            end
        end else begin
            w_word_done_nxt = 1'b0;
        end
    end

    // frame state registers
    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            r_bit_cnt   <= {SPI_CNT_W{1'b0}};
            r_rx_data   <= {WORD_BITS{1'b0}};
            r_tx_shift  <= {WORD_BITS{1'b0}};
            r_word_done <= 1'b0;
        end else begin
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_rx_data   <= w_rx_nxt;
            r_tx_shift  <= w_tx_nxt;
            r_word_done <= w_word_done_nxt;
        end
    end

    assign spi_miso      = r_tx_shift[WORD_BITS-1];
    assign spi_miso_oe   = ~w_csn_sync;
    assign bus.csn_sync  = w_csn_sync;
    assign bus.bit_cnt   = r_bit_cnt;
    assign bus.rx_data   = r_rx_data;
    assign bus.word_done = r_word_done;

endmodule

// File: tb/tb_spi_slave_phy.sv
// Self-checking bench for spi_slave_phy: randomized SPI frames against a frame-level reference model.
`timescale 1ns/1ps
module tb_spi_slave_phy;
    import spi_pkg::*;

`ifdef SPI_MODE3_EN
    localparam logic IDLE = 1'b1;
`else
    localparam logic IDLE = 1'b0;
`endif

    logic clock    = 1'b0;
    logic nreset   = 1'b0;
    logic spi_sclk = IDLE;
    logic spi_csn  = 1'b1;
    logic spi_mosi = 1'b0;
    logic spi_miso;
    logic spi_miso_oe;

    int errors   = 0;
    int checks   = 0;
    int wd_count = 0;
    int H        = 5;

    logic [31:0] fr_data [5];
    logic [31:0] fr_rd   [5];
    logic [31:0] fr_got  [5];

    // reference model: pin history (sync latency) plus frame-level counters
    logic [2:0]  h_sclk;
    logic [2:0]  h_csn;
    logic [2:0]  h_mosi;
    int          m_n;
    logic [31:0] m_rx;
    logic [31:0] m_w;
    int          m_j;
    logic        m_done;
    logic        m_csn;

    spi_slave_phy_if #(.WORD_BITS(32)) bus_if ();

    spi_slave_phy #(.WORD_BITS(32)) dut (
        .clock       (clock),
        .nreset      (nreset),
        .spi_sclk    (spi_sclk),
        .spi_csn     (spi_csn),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe),
        .bus         (bus_if.master)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
        end
    endtask

    // bit position for the n-th rising edge of a frame: 1..64, then 33..64 per extra word
    function automatic int cnt_of(input int n);
        if (n <= 64) return n;
        return 33 + (n - 33) % 32;
    endfunction

    function automatic logic exp_miso();
        if (m_j < 32) return m_w[31 - m_j];
        return 1'b0;
    endfunction

    task automatic model_reset();
        h_sclk = {3{IDLE}};
        h_csn  = 3'b111;
        h_mosi = 3'b000;
        m_n    = 0;
        m_rx   = 32'h0;
        m_w    = 32'h0;
        m_j    = 0;
        m_done = 1'b0;
        m_csn  = 1'b1;
    endtask

    task automatic model_step();
        int c;
        c      = cnt_of(m_n);
        m_done = 1'b0;
        if (h_csn[1]) begin
            m_n  = 0;
            m_rx = 32'h0;
            m_w  = 32'h0;
            m_j  = 0;
        end else if (h_sclk[1] && !h_sclk[2]) begin
            m_n++;
            m_rx   = {m_rx[30:0], h_mosi[1]};
            m_done = (cnt_of(m_n) == 32) || (cnt_of(m_n) == 64);
        end else if (!h_sclk[1] && h_sclk[2]) begin
            if (c == 32 || c == 64) begin
                m_w = bus_if.tx_data;
                m_j = 0;
            end else if (c > 32) begin
                m_j++;
            end else begin
                m_w = 32'h0;
                m_j = 0;
            end
        end
        h_sclk = {h_sclk[1:0], spi_sclk};
        h_csn  = {h_csn[1:0], spi_csn};
        h_mosi = {h_mosi[1:0], spi_mosi};
        m_csn  = h_csn[1];
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clock or negedge nreset);
            if (!nreset) model_reset();
            else model_step();
        end
    end

    // compare process: every cycle out of reset
    initial begin
        forever begin
            @(negedge clock);
            if (nreset) begin
                check("csn_sync", bus_if.csn_sync, m_csn);
                check("miso_oe", spi_miso_oe, !m_csn);
                check("bit_cnt", bus_if.bit_cnt, cnt_of(m_n));
                check("rx_data", bus_if.rx_data, m_rx);
                check("word_done", bus_if.word_done, m_done);
                check("miso", spi_miso, exp_miso());
                if (bus_if.word_done) wd_count++;
            end
        end
    end

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic send_bit(input logic b, output logic miso_b);
        spi_sclk = 1'b0;
        spi_mosi = b;
        clk_wait(H);
        miso_b   = spi_miso;
        spi_sclk = 1'b1;
        clk_wait(H);
    endtask

    task automatic run_frame(input logic [31:0] addr, input int nwords, input int stop_bits);
        logic        mb;
        logic [31:0] w;
        bus_if.tx_data = fr_rd[0];
        spi_csn = 1'b0;
        clk_wait(4);
        for (int i = 0; i < 32 * (nwords + 1); i++) begin
            if (stop_bits > 0 && i == stop_bits) break;
            if (i < 32) w = addr;
            else w = fr_data[i / 32 - 1];
            H = $urandom_range(4, 6);
            send_bit(w[31 - i % 32], mb);
            if (i >= 32) fr_got[i / 32 - 1][31 - i % 32] = mb;
            if (i == 31) begin
                check("addr_bit_cnt", bus_if.bit_cnt, 64'd32);
                check("addr_rx", bus_if.rx_data, addr);
            end
            if (i == 64) check("wrap_bit_cnt", bus_if.bit_cnt, 64'd33);
            if (i >= 32 && i % 32 == 0) bus_if.tx_data = fr_rd[i / 32];
        end
        if (stop_bits > 0) begin
            spi_csn = 1'b1;
            clk_wait(3);
            check("abort_bit_cnt", bus_if.bit_cnt, 64'd0);
            check("abort_rx", bus_if.rx_data, 64'd0);
            spi_sclk = IDLE;
        end else begin
            check("end_bit_cnt", bus_if.bit_cnt, 64'd64);
            check("end_rx", bus_if.rx_data, fr_data[nwords - 1]);
            if (IDLE == 1'b0) begin
                spi_sclk = 1'b0;
                clk_wait(4);
            end
            spi_csn = 1'b1;
        end
        clk_wait(6);
        spi_mosi = 1'b0;
    endtask

    initial begin
        int   wd0;
        int   nw;
        logic mb;
        logic [31:0] a;
        for (int k = 0; k < 5; k++) begin
            fr_data[k] = 32'h0;
            fr_rd[k]   = 32'h0;
            fr_got[k]  = 32'h0;
        end
        bus_if.tx_data = 32'h0;

        #12;
        check("rst_bit_cnt", bus_if.bit_cnt, 64'd0);
        check("rst_rx", bus_if.rx_data, 64'd0);
        check("rst_csn_sync", bus_if.csn_sync, 64'd1);
        check("rst_miso", spi_miso, 64'd0);
        check("rst_oe", spi_miso_oe, 64'd0);
        check("rst_word_done", bus_if.word_done, 64'd0);
        @(negedge clock);
        #2 nreset = 1'b1;
        clk_wait(4);

        // write frame: MISO stays 0
        fr_data[0] = 32'hA5A5_1234;
        wd0 = wd_count;
        run_frame(32'h0000_0010, 1, 0);
        check("write_miso_word", fr_got[0], 64'h0);
        check("write_word_done", wd_count - wd0, 64'd2);

        // read frame
        fr_data[0] = 32'h0;
        fr_rd[0]   = 32'hDEAD_BEEF;
        run_frame(32'h8000_0020, 1, 0);
        check("read_miso_word", fr_got[0], 64'hDEAD_BEEF);
        check("idle_oe", spi_miso_oe, 64'd0);

        // burst of three read words
        for (int k = 0; k < 4; k++) begin
            fr_data[k] = $urandom;
            fr_rd[k]   = $urandom;
        end
        wd0 = wd_count;
        run_frame(32'h8000_0100, 3, 0);
        for (int k = 0; k < 3; k++) check("burst_miso_word", fr_got[k], fr_rd[k]);
        check("burst_word_done", wd_count - wd0, 64'd4);

        // chip select raised after 17 bits
        wd0 = wd_count;
        run_frame($urandom, 1, 17);
        check("abort_word_done", wd_count - wd0, 64'd0);

        // asynchronous reset in the middle of a frame
        H = 5;
        spi_csn = 1'b0;
        clk_wait(4);
        for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)), mb);
        #3 nreset = 1'b0;
        #1;
        check("arst_bit_cnt", bus_if.bit_cnt, 64'd0);
        check("arst_rx", bus_if.rx_data, 64'd0);
        check("arst_csn_sync", bus_if.csn_sync, 64'd1);
        check("arst_oe", spi_miso_oe, 64'd0);
        check("arst_word_done", bus_if.word_done, 64'd0);
        @(negedge clock);
        spi_csn  = 1'b1;
        spi_sclk = IDLE;
        spi_mosi = 1'b0;
        clk_wait(3);
        #2 nreset = 1'b1;
        clk_wait(4);

        // randomized frames
        for (int f = 0; f < 6; f++) begin
            nw = $urandom_range(1, 3);
            a  = $urandom;
            for (int k = 0; k < 5; k++) begin
                fr_data[k] = $urandom;
                fr_rd[k]   = $urandom;
            end
            wd0 = wd_count;
            run_frame(a, nw, 0);
            for (int k = 0; k < nw; k++) check("rand_miso_word", fr_got[k], fr_rd[k]);
            check("rand_word_done", wd_count - wd0, nw + 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
